// File: rtl/spu_decode_queue.sv
// spu_decode_queue
//
// Decode stage for the SPU pipeline. Each accepted 32-bit instruction word is
// split into opcode, register fields, an extended immediate and an
// execution-unit class in a single combinational step. The decoded op is then
// written into a DEPTH-entry FIFO that feeds the issue stage.
//
// Build option:
//   SPU_DEC_ILLEGAL_TRAP_EN
//     Defined: an illegal word is not queued. It raises a sticky trap and its
//     word is captured in trap_instr. New instructions are refused while the
//     trap is set. The queue keeps draining.
//     Undefined: an illegal word is queued with out_illegal=1. trap and
//     trap_instr are tied to 0, and trap_clr has no effect.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        instruction handshake
//   in_instr[31:0]           instruction word
//   out_valid/out_ready      queue-head handshake towards issue
//   out_op[10:0]             opcode value (zero-extended to 11 bits)
//   out_rt/out_ra/out_rb     raw register fields
//   out_use_ra/rb/rt         source-operand usage flags
//   out_imm[IMM_W-1:0]       extended immediate (0 for RR and illegal)
//   out_unit[1:0]            0=simple fixed, 1=shift/rotate, 3=none
//   out_illegal              head entry is an illegal encoding
//   trap, trap_instr         sticky illegal trap and the offending word
//   trap_clr                 one-cycle pulse that clears the trap
module spu_decode_queue #(
  parameter int IMM_W = 32,
  parameter int REG_W = 7,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [10:0]       out_op,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_ra,
  output logic [REG_W-1:0]  out_rb,
  output logic              out_use_ra,
  output logic              out_use_rb,
  output logic              out_use_rt,
  output logic [IMM_W-1:0]  out_imm,
  output logic [1:0]        out_unit,
  output logic              out_illegal,
  output logic              trap,
  output logic [31:0]       trap_instr,
  input  logic              trap_clr
);

  localparam int AW = $clog2(DEPTH);

  // RR / RI7 opcodes, matched on instr[31:21]
  localparam logic [10:0] OP_AH    = 11'h0C8;
  localparam logic [10:0] OP_A     = 11'h0C0;
  localparam logic [10:0] OP_SFH   = 11'h048;
  localparam logic [10:0] OP_SF    = 11'h040;
  localparam logic [10:0] OP_ADDX  = 11'h340;
  localparam logic [10:0] OP_SFX   = 11'h341;
  localparam logic [10:0] OP_CG    = 11'h0C2;
  localparam logic [10:0] OP_BG    = 11'h042;
  localparam logic [10:0] OP_CLZ   = 11'h2A5;
  localparam logic [10:0] OP_AND   = 11'h0C1;
  localparam logic [10:0] OP_OR    = 11'h041;
  localparam logic [10:0] OP_XOR   = 11'h241;
  localparam logic [10:0] OP_NAND  = 11'h0C9;
  localparam logic [10:0] OP_NOR   = 11'h049;
  localparam logic [10:0] OP_EQV   = 11'h249;
  localparam logic [10:0] OP_CEQ   = 11'h3C0;
  localparam logic [10:0] OP_CEQH  = 11'h3C8;
  localparam logic [10:0] OP_CGT   = 11'h240;
  localparam logic [10:0] OP_CGTH  = 11'h248;
  localparam logic [10:0] OP_CGTB  = 11'h250;
  localparam logic [10:0] OP_SHLHI = 11'h07F;

  // RI16 opcodes, matched on instr[31:23]
  localparam logic [8:0]  OP_ILH   = 9'h083;
  localparam logic [8:0]  OP_IL    = 9'h081;

  // RI10 opcodes, matched on instr[31:24]
  localparam logic [7:0]  OP_AHI   = 8'h1D;
  localparam logic [7:0]  OP_AI    = 8'h1C;
  localparam logic [7:0]  OP_SFHI  = 8'h0D;
  localparam logic [7:0]  OP_SFI   = 8'h0C;
  localparam logic [7:0]  OP_ANDI  = 8'h14;
  localparam logic [7:0]  OP_ANDHI = 8'h15;
  localparam logic [7:0]  OP_ANDBI = 8'h16;
  localparam logic [7:0]  OP_ORI   = 8'h04;
  localparam logic [7:0]  OP_ORHI  = 8'h05;
  localparam logic [7:0]  OP_ORBI  = 8'h06;
  localparam logic [7:0]  OP_XORI  = 8'h44;
  localparam logic [7:0]  OP_XORHI = 8'h45;
  localparam logic [7:0]  OP_XORBI = 8'h46;
  localparam logic [7:0]  OP_CEQI  = 8'h7C;
  localparam logic [7:0]  OP_CEQHI = 8'h7D;
  localparam logic [7:0]  OP_CGTI  = 8'h4C;
  localparam logic [7:0]  OP_CGTHI = 8'h4D;
  localparam logic [7:0]  OP_CGTBI = 8'h4E;

  // RI18 opcode, matched on instr[31:25]
  localparam logic [6:0]  OP_ILA   = 7'h21;

  localparam logic [1:0]  UNIT_SIMPLE = 2'd0;
  localparam logic [1:0]  UNIT_SHIFT  = 2'd1;
  localparam logic [1:0]  UNIT_NONE   = 2'd3;

  typedef struct packed {
    logic [10:0]      op;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic             use_ra;
    logic             use_rb;
    logic             use_rt;
    logic [IMM_W-1:0] imm;
    logic [1:0]       unit;
    logic             illegal;
  } entry_t;

  function automatic logic signed [IMM_W-1:0] sext7(input logic signed [6:0] v);
    return IMM_W'(v);
  endfunction

  function automatic logic signed [IMM_W-1:0] sext10(input logic signed [9:0] v);
    return IMM_W'(v);
  endfunction

  function automatic logic signed [IMM_W-1:0] sext16(input logic signed [15:0] v);
    return IMM_W'(v);
  endfunction

  function automatic logic signed [IMM_W-1:0] zext18(input logic [17:0] v);
    return IMM_W'(v);
  endfunction

  // ---- stage p0: combinational decode of the incoming word ----
  logic [10:0]             op11_p0;
  logic [8:0]              op9_p0;
  logic [7:0]              op8_p0;
  logic [6:0]              op7_p0;
  logic signed [IMM_W-1:0] imm_p0;
  entry_t                  dec_p0;
  logic                    vld_p0;
  logic                    push_p0;

  assign op11_p0 = in_instr[31:21];
  assign op9_p0  = in_instr[31:23];
  assign op8_p0  = in_instr[31:24];
  assign op7_p0  = in_instr[31:25];

  always_comb begin
    imm_p0          = '0;
    dec_p0          = '0;
    dec_p0.rt       = REG_W'(in_instr[6:0]);
    dec_p0.ra       = REG_W'(in_instr[13:7]);
    dec_p0.rb       = REG_W'(in_instr[20:14]);
    dec_p0.unit     = UNIT_NONE;
    dec_p0.illegal  = 1'b1;

    // Widest opcode field first; the first form that matches wins.
    case (op11_p0)
      OP_AH, OP_A, OP_SFH, OP_SF, OP_ADDX, OP_SFX, OP_CG, OP_BG, OP_CLZ,
      OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_EQV, OP_CEQ, OP_CEQH,
      OP_CGT, OP_CGTH, OP_CGTB: begin
        dec_p0.op      = op11_p0;
        dec_p0.use_ra  = 1'b1;
        dec_p0.use_rb  = (op11_p0 != OP_CLZ);
        dec_p0.use_rt  = (op11_p0 == OP_ADDX) || (op11_p0 == OP_SFX);
        dec_p0.unit    = UNIT_SIMPLE;
        dec_p0.illegal = 1'b0;
      end
      OP_SHLHI: begin
        dec_p0.op      = op11_p0;
        dec_p0.use_ra  = 1'b1;
        imm_p0         = sext7(in_instr[20:14]);
        dec_p0.unit    = UNIT_SHIFT;
        dec_p0.illegal = 1'b0;
      end
      default: begin
        case (op9_p0)
          OP_ILH, OP_IL: begin
            dec_p0.op      = 11'(op9_p0);
            imm_p0         = sext16(in_instr[22:7]);
            dec_p0.unit    = UNIT_SIMPLE;
            dec_p0.illegal = 1'b0;
          end
          default: begin
            case (op8_p0)
              OP_AHI, OP_AI, OP_SFHI, OP_SFI, OP_ANDI, OP_ANDHI, OP_ANDBI,
              OP_ORI, OP_ORHI, OP_ORBI, OP_XORI, OP_XORHI, OP_XORBI,
              OP_CEQI, OP_CEQHI, OP_CGTI, OP_CGTHI, OP_CGTBI: begin
                dec_p0.op      = 11'(op8_p0);
                dec_p0.use_ra  = 1'b1;
                imm_p0         = sext10(in_instr[23:14]);
                dec_p0.unit    = UNIT_SIMPLE;
                dec_p0.illegal = 1'b0;
              end
              default: begin
                if (op7_p0 == OP_ILA) begin
                  dec_p0.op      = 11'(op7_p0);
                  imm_p0         = zext18(in_instr[24:7]);
                  dec_p0.unit    = UNIT_SIMPLE;
                  dec_p0.illegal = 1'b0;
                end
              end
            endcase
          end
        endcase
      end
    endcase

    dec_p0.imm = imm_p0;
  end

  // ---- stage p1: decoded-op queue ----
  entry_t        mem_p1 [DEPTH];
  logic [AW:0]   wr_ptr_p1;
  logic [AW:0]   rd_ptr_p1;
  logic          full_p1;
  logic          vld_p1;
  logic          pop_p1;
  entry_t        head_p1;

  // Pointers carry one extra wrap bit: equal means empty, equal except for
  // the wrap bit means full.
  assign full_p1 = (wr_ptr_p1[AW] != rd_ptr_p1[AW]) &&
                   (wr_ptr_p1[AW-1:0] == rd_ptr_p1[AW-1:0]);
  assign vld_p1  = (wr_ptr_p1 != rd_ptr_p1);
  assign pop_p1  = vld_p1 && out_ready;
  assign vld_p0  = in_valid && in_ready;

`ifdef SPU_DEC_ILLEGAL_TRAP_EN
  logic        trap_q;
  logic [31:0] trap_instr_q;
  logic        trap_set;

  assign trap_set = vld_p0 && dec_p0.illegal;
  assign push_p0  = vld_p0 && !dec_p0.illegal;
  assign in_ready = !full_p1 && !trap_q;

  // A new illegal word takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_q       <= 1'b0;
      trap_instr_q <= '0;
    end else if (trap_set) begin
      trap_q       <= 1'b1;
      trap_instr_q <= in_instr;
    end else if (trap_clr) begin
      trap_q       <= 1'b0;
    end
  end

  assign trap       = trap_q;
  assign trap_instr = trap_instr_q;
`else
  logic unused_trap_clr;

  assign unused_trap_clr = trap_clr;
  assign push_p0         = vld_p0;
  assign in_ready        = !full_p1;
  assign trap            = 1'b0;
  assign trap_instr      = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
    end else begin
      if (push_p0) wr_ptr_p1 <= wr_ptr_p1 + 1'b1;
      if (pop_p1)  rd_ptr_p1 <= rd_ptr_p1 + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) mem_p1[wr_ptr_p1[AW-1:0]] <= dec_p0;
  end

  // Fields are forced to zero whenever the queue is empty, so stale storage
  // never reaches the issue stage, including right after reset.
  assign head_p1     = vld_p1 ? mem_p1[rd_ptr_p1[AW-1:0]] : '0;

  assign out_valid   = vld_p1;
  assign out_op      = head_p1.op;
  assign out_rt      = head_p1.rt;
  assign out_ra      = head_p1.ra;
  assign out_rb      = head_p1.rb;
  assign out_use_ra  = head_p1.use_ra;
  assign out_use_rb  = head_p1.use_rb;
  assign out_use_rt  = head_p1.use_rt;
  assign out_imm     = head_p1.imm;
  assign out_unit    = head_p1.unit;
  assign out_illegal = head_p1.illegal;

endmodule

// File: doc/spu_decode_queue.md
# spu_decode_queue

Parametrised instruction decode stage with a decoded-op output queue for the SPU pipeline. Accepts one 32-bit SPU instruction word per cycle over a valid/ready handshake and cracks it into opcode, register fields, sign/zero-extended immediate and execution-unit class. Results are buffered in a DEPTH-entry FIFO that feeds the issue stage. It supersedes flat opcode matching by handling all instruction forms (RR, RI7, RI10, RI16, RI18) and by flagging or trapping on illegal encodings.

## Interface
- IMM_W, 32: width of extended immediate output (≥18)
- REG_W, 7: register-address width
- DEPTH, 4: output queue entries (power of 2, ≥2)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  decoder can accept
- in_instr  in  32  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  issue stage consumes head
- out_op  out  11  opcode as defines_pkg::Opcodes value
- out_rt/out_ra/out_rb  out  REG_W each  register fields
- out_use_ra/out_use_rb/out_use_rt  out  1 each  source-operand usage
- out_imm  out  IMM_W  extended immediate (0 for RR)
- out_unit  out  2  0=simple fixed (latency 2), 1=shift/rotate (latency 4), 3=none
- out_illegal  out  1  head is an illegal encoding
- trap  out  1  sticky illegal-instruction trap
- trap_instr  out  32  captured offending word
- trap_clr  in  1  clears trap (one-cycle pulse)

## Operation
- Fields: rt=instr[6:0], ra=[13:7], rb=[20:14]; I7=[20:14], I10=[23:14], I16=[22:7], I18=[24:7].
- Match order, first hit wins: 11-bit instr[31:21] (RR, RI7), then 9-bit [31:23] (RI16), 8-bit [31:24] (RI10), 7-bit [31:25] (RI18); compare against the low bits of the Opcodes value.
- RR: AH, A, SFH, SF, ADDX, SFX, CG, BG, CLZ, AND, OR, XOR, NAND, NOR, EQV, CEQ, CEQH, CGT, CGTH, CGTB; use_ra=1, use_rb=1 except CLZ (rb unused); ADDX/SFX also use_rt=1.
- RI7: SHLHI, imm=sext(I7), unit=1. All other legal ops unit=0.
- RI10: AHI, AI, SFHI, SFI, ANDI, ANDHI, ANDBI, ORI, ORHI, ORBI, XORI, XORHI, XORBI, CEQI, CEQHI, CGTI, CGTHI, CGTBI; imm=sext(I10), use_ra=1. Halfword/byte replication is done in execute, not here.
- RI16: ILH, IL; imm=sext(I16). RI18: ILA; imm=zext(I18). No register sources.
- Unused register-field outputs carry raw bits; use_* flags are authoritative.
- Illegal (no match): op=0, imm=0, all use_*=0, unit=3, illegal=1.
- Queue: push when in_valid&&in_ready; pop when out_valid&&out_ready; in_ready=!full (no push-through while full, even if popping). Wrap-around pointers with one extra bit for full/empty.

## Timing
- Decode is combinational into queue write; accepted instruction visible at head earliest next cycle (latency 1).
- Simultaneous push and pop on non-full, non-empty queue: occupancy unchanged. Push and pop on empty: pushed entry appears next cycle.
- Full throughput: one instruction per cycle while out_ready=1.
- Reset: queue empty, out_valid=0, in_ready=1, trap=0, trap_instr=0, all out_* fields 0. Reset mid-stream discards all queued entries.

## Configuration
- SPU_DEC_ILLEGAL_TRAP_EN defined: illegal word is not enqueued; trap sets the next cycle, trap_instr captures word, in_ready held 0 while trap=1 (queue still drains). trap_clr clears trap the next cycle. trap_clr in the same cycle as a new illegal word: set wins.
- Undefined: illegal words enqueue with out_illegal=1; trap and trap_instr tied 0; trap_clr ignored.

## Test plan
- 0x18008083 (A r3,r1,r2) -> next cycle op=00011000000, rt=3, ra=1, rb=2, use_ra/rb=1, imm=0, unit=0.
- 0x1CFFC205 (AI r5,r4,-1) -> rt=5, ra=4, imm=0xFFFFFFFF; 0x40C00002 (IL r2,0x8000) -> imm=0xFFFF8000; 0x43FFFF87 (ILA r7) -> imm=0x0003FFFF.
- out_ready=0, 5 back-to-back valids, DEPTH=4 -> in_ready drops after 4th accept; release out_ready -> 4 entries in order, 5th accepted after first pop.
- Continuous stream with out_ready=1 -> one output per cycle, occupancy constant at 1.
- 0xFFFFFFFF with trap enabled -> not queued, trap=1, trap_instr=0xFFFFFFFF, in_ready=0 until trap_clr; disabled -> queued with out_illegal=1, unit=3.
- Assert rst_n low with 3 entries queued -> out_valid=0 immediately, in_ready=1 after release, no stale entries emerge.
